// File: rtl/mem_pkg.sv
// Memory-access encodings shared by the core control, the data memory and the store buffer.
// funct3 values for loads and stores plus the access-size helper.
package mem_pkg;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b000;
    localparam logic [2:0] OP_SH  = 3'b001;
    localparam logic [2:0] OP_SW  = 3'b010;

    // Bytes touched by an access; the unused encoding 2'b11 is treated as a word.
    function automatic logic [2:0] size_of(input logic [2:0] mtype);
        case (mtype[1:0])
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// In-order store queue: entry storage, head/tail/count registers, push/pop ports,
// and a per-entry view (address, type, valid) for the hazard comparators.
module sb_fifo #(
    parameter  int DEPTH = 4,
    parameter  int AW    = 7,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [31:0]   push_data,
    input  logic [2:0]    push_type,
    input  logic          pop,
    output logic [AW-1:0] head_addr,
    output logic [31:0]   head_data,
    output logic [2:0]    head_type,
    output logic [AW-1:0] ent_addr [DEPTH],
    output logic [2:0]    ent_type [DEPTH],
    output logic [DEPTH-1:0] ent_valid,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [AW-1:0] addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [2:0]    type_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    // Entry payloads carry no reset; validity comes from head/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= push_addr;
            data_q[tail] <= push_data;
            type_q[tail] <= push_type;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            empty <= 1'b1;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            case ({push, pop})
                2'b10: begin
                    count <= count + 1'b1;
                    empty <= 1'b0;
                end
                2'b01: begin
                    count <= count - 1'b1;
                    empty <= (count == CW'(1));
                end
                default: ;
            endcase
        end
    end

    assign head_addr = addr_q[head];
    assign head_data = data_q[head];
    assign head_type = type_q[head];

    // Slot i is live when its distance from head (mod DEPTH) is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] off;
        assign off          = PW'(i) - head;
        assign ent_valid[i] = CW'(off) < count;
        assign ent_addr[i]  = addr_q[i];
        assign ent_type[i]  = type_q[i];
    end

endmodule

// File: rtl/store_buf.sv
// Store buffer between the core load/store path and dm: queues stores, retires them on
// idle cycles, stalls loads that overlap a pending store, and drains fully on a fence.
module store_buf
    import mem_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int AW    = 7,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          st_req,
    input  logic          ld_req,
    input  logic          fence_req,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [2:0]    mtype,
    output logic          stall,
    output logic [31:0]   rdata,
    output logic          dm_wr,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_din,
    output logic [2:0]    dm_type,
    input  logic [31:0]   dm_dout,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [AW-1:0]    head_addr;
    logic [31:0]      head_data;
    logic [2:0]       head_type;
    logic [AW-1:0]    ent_addr [DEPTH];
    logic [2:0]       ent_type [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic             push;
    logic             drain;
    logic             load_go;
    logic             stall_c;
    logic             hazard;
    logic [DEPTH-1:0] hit;
    logic [AW-1:0]    ld_end;

    sb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_addr (addr),
        .push_data (wdata),
        .push_type (mtype),
        .pop       (drain),
        .head_addr (head_addr),
        .head_data (head_data),
        .head_type (head_type),
        .ent_addr  (ent_addr),
        .ent_type  (ent_type),
        .ent_valid (ent_valid),
        .count     (count),
        .empty     (empty)
    );

    // Address of the last byte touched, wrapping at AW bits.
    function automatic logic [AW-1:0] last_byte(input logic [AW-1:0] a, input logic [2:0] t);
        return a + AW'(size_of(t)) - AW'(1);
    endfunction

    assign ld_end = last_byte(addr, mtype);

    // An access covers at most two words (first and last), so four compares per entry are exact.
    for (genvar i = 0; i < DEPTH; i++) begin : g_haz
        logic [AW-1:0] e_end;
        assign e_end  = last_byte(ent_addr[i], ent_type[i]);
        assign hit[i] = ent_valid[i] &&
                        (ent_addr[i][AW-1:2] == addr[AW-1:2]   ||
                         ent_addr[i][AW-1:2] == ld_end[AW-1:2] ||
                         e_end[AW-1:2]       == addr[AW-1:2]   ||
                         e_end[AW-1:2]       == ld_end[AW-1:2]);
    end

    assign hazard = |hit;

    always_comb begin
        drain   = 1'b0;
        push    = 1'b0;
        load_go = 1'b0;
        stall_c = 1'b0;
        if (ld_req) begin
            if (hazard) begin
                stall_c = 1'b1;
                drain   = 1'b1;
            end else begin
                load_go = 1'b1;
            end
        end else if (st_req) begin
            if (count == CW'(DEPTH)) begin
                stall_c = 1'b1;
                drain   = 1'b1;
            end else begin
                push = 1'b1;
            end
        end else if (fence_req) begin
            if (!empty) begin
                stall_c = 1'b1;
                drain   = 1'b1;
            end
        end else if (!empty) begin
            drain = 1'b1;
        end
    end

    always_comb begin
        stall   = stall_c & rstn;
        dm_wr   = drain & rstn;
        dm_addr = '0;
        dm_din  = '0;
        dm_type = '0;
        rdata   = '0;
        if (drain) begin
            dm_addr = head_addr;
            dm_din  = head_data;
            dm_type = head_type;
        end else if (load_go) begin
            dm_addr = addr;
            dm_type = mtype;
            rdata   = dm_dout;
        end
    end

endmodule
